dm_lsu: RTL
===========

Name: dm_lsu

Overview:
- Load/store unit: the initiator side of the word-wide data-memory interface.
- Accepts one CPU memory operation at a time (lw/lh/lhu/lb/lbu/sw/sh/sb) and checks alignment and range.
- Issues word-aligned read/write transactions over a req/ready handshake.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words. Load results are extracted and extended here.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
- ADDR_W, 32, width of cpu_addr and mem_addr.
- DM_BYTES, 12288, size of the data memory in bytes. Any access with addr >= DM_BYTES is out of range.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cpu_valid  in  1  operation request. Sampled only when cpu_ready=1.
- cpu_ready  out  1  LSU is in IDLE and can accept.
- cpu_op  in  3  operation code (see package).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data. Low byte/half is used for sb/sh.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_exc  out  1  valid with cpu_done. 1 = misaligned or out-of-range; no memory access was made.
- cpu_rdata  out  32  extended load result. Holds its value until the next successful load.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req=1.
- mem_addr  out  ADDR_W  word-aligned address (low two bits always 0).
- mem_wdata  out  32  full write word.
- mem_ready  in  1  memory completes the current transaction at this posedge.
- mem_rdata  in  32  read word. Valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset values: state=IDLE, cpu_ready=1, cpu_done=0, cpu_exc=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the operation. No cpu_done is produced, and mem_req is 0 from the cycle after reset is sampled.
- Acceptance: in IDLE with cpu_valid=1, latch op, addr and wdata at the posedge. Inputs may change afterwards.
- Exception check at acceptance:
  - halfword ops: addr[0]!=0 is misaligned;
  - word ops: addr[1:0]!=0 is misaligned;
  - addr >= DM_BYTES is out of range.
  - Any failure -> go to DONE with exc=1.
- State machine: IDLE, RD, WR, DONE.
  - IDLE -> RD for loads, sh and sb.
  - IDLE -> WR for sw.
  - IDLE -> DONE on exception.
  - RD: mem_req=1, mem_we=0. On mem_ready: a load captures the extended result into cpu_rdata and goes to DONE. sh/sb merge the store data into the returned word (the target lane is set by addr[1:0]; the other bytes are unchanged), register the merged word as wdata, and go to WR.
  - WR: mem_req=1, mem_we=1. On mem_ready go to DONE.
  - DONE: cpu_done=1 for exactly one cycle, then IDLE. cpu_ready=0 in every state except IDLE.
- mem_addr and mem_wdata stay stable while mem_req=1 and mem_ready=0. mem_ready is ignored when mem_req=0.
- Load extraction:
  - byte = word[8*addr[1:0] +: 8];
  - half = word[16*addr[1] +: 16];
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
- Latency from the accept edge to the cycle in which cpu_done=1, with mem_ready tied high: exception 1 cycle, load or sw 2 cycles, sh/sb 3 cycles. Each wait cycle on mem_ready adds 1.
- Stores and exceptions leave cpu_rdata unchanged.
- cpu_exc is 0 whenever cpu_done=0.

Decomposition:
- Package dm_lsu_pkg holds:
  - op codes: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7;
  - state encoding: IDLE=0, RD=1, WR=2, DONE=3;
  - helper functions is_load, is_subword_store and access_size.
- One sub-module, dm_lane_unit, is natural: a purely combinational block that does byte/half extraction with extension, and store merging. It is shared by the RD path.

Test Plan:
- Preload word 0x80F0_1234 at 0x10, mem_ready tied 1. lb 0x11, lbu 0x11, lh 0x12, lhu 0x12, lw 0x10 -> cpu_rdata 0x0000_0012, 0x0000_0012, 0xFFFF_80F0, 0x0000_80F0, 0x80F0_1234. Each cpu_done fires 2 cycles after accept.
- Word 0x1122_3344 at 0x20. sb 0x23 with wdata 0xAB -> one read, then a write of 0xAB22_3344 to 0x20; done 3 cycles after accept. Then sh 0x20 with wdata 0xBEEF -> 0xAB22_BEEF.
- lw 0x0000_0002, sh 0x0000_0001, and sb at 0x0000_3000 (DM_BYTES) -> each gives cpu_done=1 with cpu_exc=1 one cycle after accept, mem_req never asserted, cpu_rdata unchanged.
- mem_ready held 0 for 3 cycles during sw 0x40 = 0xDEAD_BEEF -> mem_req, mem_we, mem_addr=0x40 and mem_wdata stable across the wait; done 5 cycles after accept; cpu_valid pulses during the wait are ignored.
- Reset asserted while in WR of an sb -> next cycle mem_req=0, cpu_ready=1, no cpu_done, cpu_rdata=0.
- Back-to-back: cpu_valid held high with alternating sw/lw to the same address -> each lw returns the preceding sw data, and cpu_ready is high only in IDLE cycles.

Source files
------------

// File: rtl/dm_lsu_pkg.sv
// Shared types and decode helpers for the dm_lsu load/store unit.
package dm_lsu_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic logic is_load(input op_e op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_subword_store(input op_e op);
        return (op == SH) || (op == SB);
    endfunction

    function automatic size_e access_size(input op_e op);
        size_e sz;
        case (op)
            LB, LBU, SB: sz = SZ_BYTE;
            LH, LHU, SH: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dm_lsu_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module dm_lane_unit
    import dm_lsu_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [15:0] st_half,
    output logic [31:0] ld_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_word[{byte_off, 3'b000} +: 8];
    assign half_sel = rd_word[{byte_off[1], 4'b0000} +: 16];

    // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        ld_data     = rd_word;
        merged_word = rd_word;
        case (op)
            LB:      ld_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ld_data = {24'h0, byte_sel};
            LH:      ld_data = {{16{half_sel[15]}}, half_sel};
            LHU:     ld_data = {16'h0, half_sel};
            SB:      merged_word[{byte_off, 3'b000} +: 8] = st_half[7:0];
            SH:      merged_word[{byte_off[1], 4'b0000} +: 16] = st_half;
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: accepts one CPU memory op, checks it, and runs the word-wide
// read / write / read-modify-write transactions against the data memory.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DM_BYTES = 12288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [2:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_exc,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    state_e      state;
    op_e         op_q;
    logic [1:0]  off_q;
    op_e         op_in;
    size_e       size_in;
    logic        exc_in;
    logic [31:0] ld_data;
    logic [31:0] merged_word;

    assign op_in   = op_e'(cpu_op);
    assign size_in = access_size(op_in);
    assign exc_in  = ((size_in == SZ_HALF) && cpu_addr[0])
                  || ((size_in == SZ_WORD) && (cpu_addr[1:0] != 2'b00))
                  || (cpu_addr >= ADDR_W'(DM_BYTES));

    // mem_wdata doubles as the store-data holder, so the merge reads its low half.
    dm_lane_unit u_lane (
        .op          (op_q),
        .byte_off    (off_q),
        .rd_word     (mem_rdata),
        .st_half     (mem_wdata[15:0]),
        .ld_data     (ld_data),
        .merged_word (merged_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= LW;
            off_q     <= 2'b00;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_exc   <= 1'b0;
            cpu_rdata <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        op_q      <= op_in;
                        off_q     <= cpu_addr[1:0];
                        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        if (exc_in) begin
                            state    <= DONE;
                            cpu_done <= 1'b1;
                            cpu_exc  <= 1'b1;
                        end else if (is_load(op_in) || is_subword_store(op_in)) begin
                            state   <= RD;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end else begin
                            state   <= WR;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        if (is_load(op_q)) begin
                            state     <= DONE;
                            cpu_rdata <= ld_data;
                            cpu_done  <= 1'b1;
                            mem_req   <= 1'b0;
                        end else begin
                            state     <= WR;
                            mem_wdata <= merged_word;
                            mem_we    <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        state    <= DONE;
                        cpu_done <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cpu_done  <= 1'b0;
                    cpu_exc   <= 1'b0;
                    cpu_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
